// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
//   dmem_state_t : controller FSM states (IDLE, WAIT, RESP)
//   SZ_*         : req_size encodings (2'b11 behaves as a word access)
//   CNT_W        : width of the wait-state counter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   size     : access size (SZ_BYTE / SZ_HALF / word)
//   addr_lo  : byte offset within the word, addr[1:0]
//   sext     : sign-extend byte/halfword loads
//   wdata    : store data, byte/halfword taken from the low bits
//   rword    : raw 32-bit word read from the array
//   be       : byte-lane write enables (little-endian)
//   wword    : store data replicated into every candidate lane
//   rdata    : selected load data, zero- or sign-extended to 32 bits
//   misalign : halfword with addr[0]=1 or word with addr[1:0]!=0
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic s);
    logic signed [7:0] sb;
    sb = b;
    return s ? 32'(sb) : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic s);
    logic signed [15:0] sh;
    sh = h;
    return s ? 32'(sh) : {16'd0, h};
  endfunction

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be       = 4'b1111;
    wword    = wdata;
    rdata    = rword;
    misalign = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        rdata = ext_byte(rbyte, sext);
      end
      SZ_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rdata    = ext_half(rhalf, sext);
        misalign = addr_lo[0];
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked MEM-stage data memory with configurable SRAM wait states.
// One load/store in flight; busy freezes the pipeline until the response.
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   req_valid/ready  : request handshake, accepted only in IDLE
//   req_we/size/sext : store flag, access size, load sign-extension
//   req_addr/wdata   : byte address (wraps modulo DEPTH_WORDS*4), store data
//   resp_valid       : one-cycle completion pulse for loads and stores
//   resp_rdata       : last load result, held across store responses
//   resp_err         : misaligned access flag, meaningful with resp_valid
//   busy             : high whenever the controller is not IDLE
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned
// halfword/word accesses (no write, rdata cleared, resp_err raised).
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, access;

  logic             we_p0, sext_p0;
  logic [1:0]       size_p0;
  logic [IDX_W+1:0] addr_p0;
  logic [31:0]      wdata_p0;

  logic             op_we, op_sext;
  logic [1:0]       op_size;
  logic [IDX_W+1:0] op_addr;
  logic [31:0]      op_wdata;
  logic [IDX_W-1:0] op_idx;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rword, wword, ld_data;
  logic [3:0]       be;
  logic             lane_misalign, bad;

  // Address bits above the array index are deliberately ignored (wrap).
  logic unused_addr;
  assign unused_addr = ^req_addr;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by rst so no request is acknowledged while reset is held.
        req_ready = rst;
        if (req_valid && rst) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = req_valid && req_ready;
  assign access     = (state_nxt == RESP);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_err   = resp_valid && bad;

  // With zero wait states the access happens on the handshake edge itself,
  // before the request latches are loaded, so IDLE uses the live inputs.
  assign op_we    = (state == IDLE) ? req_we                 : we_p0;
  assign op_size  = (state == IDLE) ? req_size               : size_p0;
  assign op_sext  = (state == IDLE) ? req_sext               : sext_p0;
  assign op_addr  = (state == IDLE) ? req_addr[IDX_W+1:0]    : addr_p0;
  assign op_wdata = (state == IDLE) ? req_wdata              : wdata_p0;
  assign op_idx   = op_addr[IDX_W+1:2];
  assign rword    = mem[op_idx];

  dmem_lane_align u_align (
    .size     (op_size),
    .addr_lo  (op_addr[1:0]),
    .sext     (op_sext),
    .wdata    (op_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (ld_data),
    .misalign (lane_misalign)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = lane_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = lane_misalign;
  assign bad = 1'b0;
`endif

  // Control state: FSM, wait counter and load-result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (access && (bad || !op_we)) begin
        resp_rdata <= bad ? '0 : ld_data;
      end
    end
  end

  // Request latch stage (_p0): captured once at handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      sext_p0  <= req_sext;
      addr_p0  <= req_addr[IDX_W+1:0];
      wdata_p0 <= req_wdata;
    end
  end

  // Array write on the RESP-entry edge; not touched by reset
  always_ff @(posedge clk) begin
    if (access && op_we && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[op_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: two instances (2 and 0 wait
// states) sharing clock and reset, driven by directed and random accesses
// and compared against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int DEPTH = 16;
  localparam int WC [2] = '{2, 0};
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic        req_sext  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        busy      [2];

  logic [31:0] mdl     [2][DEPTH];
  logic [31:0] last_rd [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_sext(req_sext[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_sext(req_sext[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic randomize_inputs(input int d);
    req_we[d]    = 1'($urandom);
    req_size[d]  = 2'($urandom);
    req_sext[d]  = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
  endtask

  // Reference: memory as bytes, lanes chosen by size, extension by arithmetic.
  task automatic model(input int d, input bit we, input logic [1:0] size, input bit sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_rd, output bit exp_err);
    int    idx, n, start;
    longint v;
    idx   = int'((addr >> 2) % DEPTH);
    n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    start = (n == 1) ? int'(addr % 4) : (n == 2) ? int'((addr % 4) / 2) * 2 : 0;
    exp_err = ALIGN && ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0));
    if (exp_err) begin
      last_rd[d] = 32'd0;
    end else if (we) begin
      for (int k = 0; k < n; k++) mdl[d][idx][8*(start+k) +: 8] = wdata[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(mdl[d][idx][8*(start+k) +: 8]) << (8*k);
      if (sext && n < 4 && v >= (64'sd1 << (8*n-1))) v -= (64'sd1 << (8*n));
      last_rd[d] = v[31:0];
    end
    exp_rd = last_rd[d];
  endtask

  // Entered just after a rising edge with instance d idle; leaves the same way.
  task automatic access(input int d, input bit we, input logic [1:0] size, input bit sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    bit          got;
    check($sformatf("ready_idle%0d", d), 32'(req_ready[d]), 32'd1);
    req_we[d] = we; req_size[d] = size; req_sext[d] = sext;
    req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    model(d, we, size, sext, addr, wdata, exp_rd, exp_err);
    // Later input changes (and requests while busy) must have no effect.
    randomize_inputs(d);
    req_valid[d] = 1'($urandom);
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check($sformatf("busy%0d", d), 32'(busy[d]), 32'd1);
      if (resp_valid[d]) got = 1;
    end
    req_valid[d] = 1'b0;
    check($sformatf("latency%0d", d), 32'(lat), 32'(WC[d] + 1));
    check($sformatf("rdata%0d", d), resp_rdata[d], exp_rd);
    check($sformatf("err%0d", d), 32'(resp_err[d]), 32'(exp_err));
    rd = resp_rdata[d];
    @(posedge clk); #1;
    check($sformatf("pulse%0d", d), 32'(resp_valid[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, old;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      randomize_inputs(d);
    end

    // Reset held three cycles with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        randomize_inputs(d);
        req_valid[d] = 1'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_ready", 32'(req_ready[d]), 32'd0);
        check("rst_valid", 32'(resp_valid[d]), 32'd0);
        check("rst_rdata", resp_rdata[d], 32'd0);
        check("rst_err", 32'(resp_err[d]), 32'd0);
        check("rst_busy", 32'(busy[d]), 32'd0);
      end
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    rst = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("post_rst_ready", 32'(req_ready[d]), 32'd1);
      check("post_rst_busy", 32'(busy[d]), 32'd0);
    end
    @(posedge clk); #1;

    // Give every word a known value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) access(d, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd);

    // Word store then load.
    access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    check("word_load", rd, 32'hDEADBEEF);

    // Byte store with sign/zero-extended loads.
    access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rd);
    access(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hAAAA_AA80, rd);
    access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
    check("byte_in_word", rd, 32'h00008000);
    access(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd);
    check("byte_sext", rd, 32'hFFFFFF80);
    access(0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd);
    check("byte_zext", rd, 32'h00000080);
    access(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_9abc, rd);
    access(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd);
    check("half_sext", rd, 32'hFFFF9ABC);

    // Address wrap on the zero-wait instance.
    access(1, 1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h12345678, rd);
    access(1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd);
    check("wrap", rd, 32'h12345678);
    access(1, 1'b1, 2'b00, 1'b0, 32'h8000_0005, 32'h0000_00C3, rd);
    access(1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, rd);
    access(1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd);
    check("store_rdata_hold", rd, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd);
    access(0, 1'b1, 2'b10, 1'b0, 32'h02, 32'h55555555, rd);
    access(0, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, rd);
    check("misalign_rdata", rd, 32'h0);
`endif

    // Random traffic on both instances.
    for (int t = 0; t < 300; t++) begin
      int d;
      d = int'($urandom_range(1, 0));
      access(d, 1'($urandom), 2'($urandom), 1'($urandom),
             (t % 3 == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom, $urandom, rd);
    end

    // Reset during the wait states discards the store.
    access(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, old);
    req_we[0] = 1'b1; req_size[0] = 2'b10; req_sext[0] = 1'b0;
    req_addr[0] = 32'h8; req_wdata[0] = ~old; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("mid_busy_before", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[0]), 32'd0);
    check("mid_rst_rdata", resp_rdata[0], 32'd0);
    check("mid_rst_rdata1", resp_rdata[1], 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd);
    check("rst_discard", rd, old);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "simulation time limit");
  end

endmodule
